// File: rtl/bw_io_jp_tap_ctl.sv
// bw_io_jp_tap_ctl: IEEE 1149.1 TAP controller running on rclk.
// TCK edges arrive as tck_en; drives the BSR chain controls and tdo.
module bw_io_jp_tap_ctl #(
    parameter logic [31:0] IDCODE = 32'h0000_103F,
    parameter int          IR_W   = 4
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            tck_en,
    input  logic            tms,
    input  logic            tdi,
    input  logic            bsr_so,
    output logic            tdo,
    output logic            tdo_en,
    output logic            bsr_si,
    output logic            shift_dr,
    output logic            clock_dr,
    output logic            update_dr,
    output logic [IR_W-1:0] ir_q
);

    localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    typedef enum logic [3:0] {
        TLR,
        RTI,
        SEL_DR,
        CAP_DR,
        SH_DR,
        EX1_DR,
        PAUSE_DR,
        EX2_DR,
        UPD_DR,
        SEL_IR,
        CAP_IR,
        SH_IR,
        EX1_IR,
        PAUSE_IR,
        EX2_IR,
        UPD_IR
    } tap_e;

    tap_e            state;
    tap_e            state_nx;
    logic [IR_W-1:0] ir_sr;
    logic [31:0]     id_sr;
    logic            bypass;
    logic            bsr_sel;
    logic            id_sel;
    logic            dr_lsb;
    logic            upd_nx;
    logic            tdo_en_nx;

    always_ff @(posedge rclk) begin
        if (rst) begin
            state <= TLR;
        end else if (tck_en) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            TLR:      state_nx = tms ? TLR    : RTI;
            RTI:      state_nx = tms ? SEL_DR : RTI;
            SEL_DR:   state_nx = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_nx = tms ? EX1_DR : SH_DR;
            SH_DR:    state_nx = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_nx = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nx = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nx = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_nx = tms ? SEL_DR : RTI;
            SEL_IR:   state_nx = tms ? TLR    : CAP_IR;
            CAP_IR:   state_nx = tms ? EX1_IR : SH_IR;
            SH_IR:    state_nx = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_nx = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nx = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nx = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_nx = tms ? SEL_DR : RTI;
        endcase
    end

    // Undefined instruction codes fall through to bypass.
    always_comb begin
        bsr_sel = 1'b0;
        id_sel  = 1'b0;
        unique case (1'b1)
            (ir_q == IR_EXTEST),
            (ir_q == IR_SAMPLE): bsr_sel = 1'b1;
            (ir_q == IR_IDCODE): id_sel  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        shift_dr  = bsr_sel && (state == SH_DR);
        clock_dr  = !rst && tck_en && bsr_sel &&
                    ((state == CAP_DR) || (state == SH_DR));
        upd_nx    = bsr_sel && (state_nx == UPD_DR);
        tdo_en_nx = (state_nx == SH_DR) || (state_nx == SH_IR);
        if (bsr_sel) begin
            dr_lsb = bsr_so;
        end else if (id_sel) begin
            dr_lsb = id_sr[0];
        end else begin
            dr_lsb = bypass;
        end
    end

    assign bsr_si = tdi;

    always_ff @(posedge rclk) begin
        if (rst) begin
            ir_q      <= IR_IDCODE;
            ir_sr     <= IR_CAPTURE;
            id_sr     <= IDCODE;
            bypass    <= 1'b0;
            tdo       <= 1'b0;
            tdo_en    <= 1'b0;
            update_dr <= 1'b0;
        end else begin
            update_dr <= 1'b0;
            if (tck_en) begin
                tdo_en    <= tdo_en_nx;
                update_dr <= upd_nx;
                case (state)
                    CAP_IR: ir_sr <= IR_CAPTURE;
                    SH_IR: begin
                        tdo   <= ir_sr[0];
                        ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                    end
                    CAP_DR: begin
                        bypass <= 1'b0;
                        id_sr  <= IDCODE;
                    end
                    SH_DR: begin
                        tdo <= dr_lsb;
                        if (id_sel) begin
                            id_sr <= {tdi, id_sr[31:1]};
                        end else if (!bsr_sel) begin
                            bypass <= tdi;
                        end
                    end
                    default: ;
                endcase
                // Leaving via tms into TLR behaves like a reset of the IR.
                if (state_nx == TLR) begin
                    ir_q <= IR_IDCODE;
                end else if (state_nx == UPD_IR) begin
                    ir_q <= ir_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_bw_io_jp_tap_ctl.sv
// tb_bw_io_jp_tap_ctl: directed scans
// plus random traffic vs a TAP model.
module tb_bw_io_jp_tap_ctl;

  localparam logic [31:0] ID = 32'h0000_103F;

  logic       rclk = 1'b0;
  logic       rst;
  logic       tck_en;
  logic       tms;
  logic       tdi;
  logic       bsr_so;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_si;
  logic       shift_dr;
  logic       clock_dr;
  logic       update_dr;
  logic [3:0] ir_q;

  int total = 0;
  int bad   = 0;

  bw_io_jp_tap_ctl #(
    .IDCODE(ID),
    .IR_W(4)
  ) dut (
    .rclk(rclk),
    .rst(rst),
    .tck_en(tck_en),
    .tms(tms),
    .tdi(tdi),
    .bsr_so(bsr_so),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .bsr_si(bsr_si),
    .shift_dr(shift_dr),
    .clock_dr(clock_dr),
    .update_dr(update_dr),
    .ir_q(ir_q)
  );

  always #5 rclk = ~rclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, o, e);
    end
  endtask

  int n0[16] = '{1, 1, 3, 4, 4, 6, 6, 4,
                 1, 10, 11, 11, 13, 13, 11, 1};
  int n1[16] = '{0, 2, 9, 5, 5, 8, 7, 8,
                 2, 0, 12, 12, 15, 14, 15, 2};

  int         m_st = 0;
  logic [3:0] m_ir = 4'b0010;
  bit         m_tdo, m_tdoen, m_upd, m_valid;
  bit         irq[$];
  bit         dq[$];
  bit [31:0]  idv;
  bit         last_so;
  int         n_clk, n_sh, n_upd;

  function automatic bit is_bsr(
    input logic [3:0] c
  );
    return (c == 4'd0) || (c == 4'd1);
  endfunction

  function automatic bit is_id(
    input logic [3:0] c
  );
    return c == 4'd2;
  endfunction

  task automatic model(
    input bit r,
    input bit te,
    input bit m,
    input bit d,
    input bit so
  );
    int ns;
    if (r) begin
      m_st = 0;
      m_ir = 4'b0010;
      m_tdo = 0;
      m_tdoen = 0;
      m_upd = 0;
      m_valid = 1;
      irq = {};
      dq = {};
      return;
    end
    m_upd = 0;
    if (!te) return;
    ns = m ? n1[m_st] : n0[m_st];
    case (m_st)
      3: begin
        dq = {};
        if (is_id(m_ir)) begin
          for (int i = 0; i < 32; i++)
            dq.push_back(idv[i]);
        end else if (!is_bsr(m_ir)) begin
          dq.push_back(1'b0);
        end
      end
      4: begin
        if (is_bsr(m_ir)) begin
          m_tdo = so;
        end else begin
          m_tdo = dq.pop_front();
          dq.push_back(d);
        end
      end
      10: irq = '{1'b1, 1'b0, 1'b0, 1'b0};
      11: begin
        m_tdo = irq.pop_front();
        irq.push_back(d);
      end
      default: ;
    endcase
    if (ns == 15)
      m_ir = {irq[3], irq[2], irq[1], irq[0]};
    if (ns == 0) m_ir = 4'b0010;
    m_upd   = (ns == 8) && is_bsr(m_ir);
    m_tdoen = (ns == 4) || (ns == 11);
    m_st    = ns;
  endtask

  task automatic tick(
    input bit r,
    input bit te,
    input bit m,
    input bit d
  );
    bit so;
    so = 1'($urandom_range(0, 1));
    rst = r;
    tck_en = te;
    tms = m;
    tdi = d;
    bsr_so = so;
    last_so = so;
    @(negedge rclk);
    if (m_valid) begin
      chk("clock_dr", clock_dr,
          !r && te && is_bsr(m_ir) &&
          (m_st == 3 || m_st == 4));
      chk("shift_dr", shift_dr,
          is_bsr(m_ir) && (m_st == 4));
      chk("bsr_si", bsr_si, d);
    end
    if (clock_dr) n_clk++;
    if (shift_dr) n_sh++;
    @(posedge rclk);
    model(r, te, m, d, so);
    #1;
    chk("tdo", tdo, m_tdo);
    chk("tdo_en", tdo_en, m_tdoen);
    chk("update_dr", update_dr, m_upd);
    chk("ir_q", ir_q, m_ir);
    if (update_dr) n_upd++;
  endtask

  task automatic ir_scan(
    input  logic [3:0] code,
    output logic [3:0] out
  );
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, i == 3, code[i]);
      out[i] = tdo;
    end
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
  endtask

  task automatic dr_scan(
    input  int          n,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] sos
  );
    dout = '0;
    sos  = '0;
    n_clk = 0;
    n_sh = 0;
    n_upd = 0;
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < n; i++) begin
      tick(0, 1, i == n - 1, din[i]);
      dout[i] = tdo;
      sos[i]  = last_so;
    end
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
  endtask

  logic [31:0] dout, sos, din;
  logic [3:0]  iro;

  initial begin
    idv = ID;
    rst = 1'b1;
    tck_en = 1'b0;
    tms = 1'b0;
    tdi = 1'b0;
    bsr_so = 1'b0;

    tick(1, 1, 1, 0);
    chk("rst_ir", ir_q, 4'b0010);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_en", tdo_en, 1'b0);
    chk("rst_upd", update_dr, 1'b0);
    tick(0, 1, 0, 0);
    chk("rti_ir", ir_q, 4'b0010);
    chk("rti_shift", shift_dr, 1'b0);

    dr_scan(32, 32'h0, dout, sos);
    chk("id_stream", dout, ID);
    chk("id_first", dout[0], 1'b1);
    chk("id_no_clk", n_clk, 0);

    ir_scan(4'b0000, iro);
    chk("ir_capture", iro, 4'b0001);
    chk("ir_extest", ir_q, 4'b0000);
    din = $urandom;
    dr_scan(8, din, dout, sos);
    chk("bsr_stream", dout[7:0], sos[7:0]);
    chk("bsr_clk_cnt", n_clk, 9);
    chk("bsr_sh_cnt", n_sh, 8);
    chk("bsr_upd_cnt", n_upd, 1);

    ir_scan(4'b1111, iro);
    chk("ir_bypass", ir_q, 4'b1111);
    dr_scan(4, 32'b1101, dout, sos);
    chk("byp_stream", dout[3:0], 4'b1010);
    chk("byp_clk_cnt", n_clk, 0);
    chk("byp_sh_cnt", n_sh, 0);
    chk("byp_upd_cnt", n_upd, 0);

    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("shdr_tdo_en", tdo_en, 1'b1);
    n_upd = 0;
    for (int p = 0; p < 5; p++) begin
      for (int g = 0; g < 3; g++)
        tick(0, 0, 1, 1'($urandom_range(0, 1)));
      tick(0, 1, 1, 0);
      if (p == 3)
        chk("tlr_pre_ir", ir_q, 4'b1111);
    end
    chk("tlr_ir", ir_q, 4'b0010);
    chk("tlr_tdo_en", tdo_en, 1'b0);
    chk("tlr_no_upd", n_upd, 0);

    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    chk("mid_ir_tdo_en", tdo_en, 1'b1);
    tick(1, 1, 0, 1);
    chk("abort_ir", ir_q, 4'b0010);
    chk("abort_tdo_en", tdo_en, 1'b0);
    chk("abort_tdo", tdo, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/bw_io_jp_tap_ctl.md
Name: bw_io_jp_tap_ctl

Overview:
- IEEE 1149.1 TAP controller: the control end of the boundary-scan register (BSR) chain.
- Runs the 16-state TAP FSM and holds a 4-bit instruction register, a bypass register and an IDCODE register.
- Drives the chain controls shift_dr, clock_dr and update_dr into the BSR cells, and launches/collects serial data at the chain ends.
- Operates entirely on rclk; each TCK rising edge arrives as a one-cycle tck_en qualifier from the pad synchronizer.

Parameters:
- IDCODE, 32'h0_0001_03F, device ID; bit0 must be 1.
- IR_W, 4, instruction register width.

Ports:
- rclk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tck_en  in  1  one-rclk pulse per TCK rising edge; the FSM and shift registers advance only when it is 1.
- tms  in  1  test mode select, sampled when tck_en=1.
- tdi  in  1  test data in, sampled when tck_en=1.
- bsr_so  in  1  serial return from the last BSR cell.
- tdo  out  1  test data out, registered.
- tdo_en  out  1  tdo output enable, high in Shift-IR and Shift-DR.
- bsr_si  out  1  serial data into the first BSR cell; equals tdi.
- shift_dr  out  1  BSR scan enable; level.
- clock_dr  out  1  BSR capture/shift clock enable; one-rclk pulse.
- update_dr  out  1  BSR update strobe; one-rclk pulse.
- ir_q  out  IR_W  current instruction, for downstream decode.

Behaviour:
Reset (rst=1 on a rclk edge, overrides tck_en):
- FSM enters TLR; ir_q=4'b0010 (IDCODE).
- Bypass register=0; IDCODE shift register=IDCODE.
- tdo=0, tdo_en=0, shift_dr=0, clock_dr=0, update_dr=0.

FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Standard 1149.1 transitions on tms, taken only on rclk edges with tck_en=1.
- tck_en=0: all state and outputs hold, except the clock_dr and update_dr pulses, which return to 0.
- tms=1 for 5 consecutive tck_en pulses reaches TLR from any state.
- Entering TLR via tms loads ir_q=IDCODE, exactly as reset does.

Instructions:
- 4'b0000 EXTEST and 4'b0001 SAMPLE select the BSR ("bsr_sel").
- 4'b0010 IDCODE selects the IDCODE register.
- 4'b1111 BYPASS, and every undefined code, selects the bypass register.

Instruction register:
- CapIR loads the IR shift register with 4'b0001.
- ShIR shifts it right, tdi entering the MSB.
- UpdIR copies the shift register to ir_q.

Data registers:
- CapDR: bypass<=0; IDCODE shift register<=IDCODE.
- ShDR: the selected register shifts right from tdi.

BSR controls (only when bsr_sel=1):
- shift_dr=1 when state==ShDR; 0 in all other states, including PauseDR.
- clock_dr pulses high for the single rclk cycle of a tck_en edge taken while state is CapDR or ShDR.
- update_dr pulses high for the one rclk cycle after the FSM enters UpdDR.
- With bsr_sel=0, all three stay 0.

tdo:
- Updates on a tck_en edge while in ShIR/ShDR, to the LSB of the selected register before the shift; holds otherwise.
- Selected register: IR shift register in ShIR; bsr_so, bypass or IDCODE LSB in ShDR.
- Net effect: a bypass scan delays tdi by 1 tck_en.

Other:
- tdo_en is registered, set on entry to ShIR/ShDR and cleared on exit.
- Reset mid-scan aborts the scan: no update_dr is issued and ir_q returns to IDCODE.
- Simultaneous rst and tck_en: reset wins.

Test Plan:
- Reset, then tms=0 for 1 tck_en -> state RTI, ir_q=4'b0010, all BSR controls 0.
- Reach ShDR under IDCODE and shift 32 bits with tdi=0 -> tdo stream, LSB first, equals IDCODE; the first bit is 1.
- IR scan with tdi=0,0,0,0 then UpdIR, followed by a DR scan of 8 bits -> ir_q=0; clock_dr pulses 1 (capture) + 8 (shift) times; shift_dr high exactly through the ShDR cycles; a single update_dr pulse on entering UpdDR; the tdo stream equals the bsr_so stream.
- Load BYPASS (1111), shift tdi=1,0,1,1 -> tdo=0,1,0,1; shift_dr, clock_dr and update_dr stay 0 throughout.
- From ShDR, drive tms=1 for 5 tck_en with tck_en gaps of 3 rclk between pulses -> TLR reached on the 5th pulse, no update_dr issued, ir_q=4'b0010, state holds during the gaps.
- Assert rst mid-ShIR with an undefined code partially shifted -> next cycle: TLR, ir_q=4'b0010, tdo_en=0.
